mb_cam_ctl: RTL and testbench

Miss-buffer controller that owns the 16-entry x 40-bit dual-ported miss-buffer CAM (`bw_r_cm16x40b`) from the initiating side. It accepts load-miss physical addresses and looks each one up against pending entries. On a miss it allocates the lowest free entry and writes it; on a hit it reports the matching entry. On fill return it reads back and frees the entry. It sits between the LSU miss path and the CAM macro and generates every CAM write, read and lookup.

---
 rtl/mb_cam_ctl_pkg.sv | 28 ++
 rtl/mb_pri_enc16.sv | 19 +
 rtl/mb_cam_ctl.sv | 206 ++++++++++++++++++++
 tb/tb_mb_cam_ctl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mb_cam_ctl_pkg.sv
// Shared definitions for the miss-buffer CAM controller: sizes, FSM encoding
// and the one-hot wordline decode.
package mb_cam_ctl_pkg;

  localparam int ENTRIES = 16;
  localparam int PA_W    = 40;
  localparam int KEY_LSB = 8;
  localparam int KEY_W   = PA_W - KEY_LSB;
  localparam int IDX_W   = 4;
  localparam int CNT_W   = 5;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LKP  = 3'd1,
    CMP  = 3'd2,
    WR   = 3'd3,
    RD   = 3'd4,
    RDC  = 3'd5
  } mb_state_e;

  function automatic logic [ENTRIES-1:0] onehot16(input logic [IDX_W-1:0] idx);
    logic [ENTRIES-1:0] v;
    v      = {ENTRIES{1'b0}};
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/mb_pri_enc16.sv
// Lowest-set-bit finder over a 16-bit vector; used for free-entry and hit selection.
module mb_pri_enc16
  import mb_cam_ctl_pkg::*;
(
  input  logic [ENTRIES-1:0] i_vec,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_found
);

  // Scan from the top so the last write wins with the lowest set bit
  always_comb begin
    o_idx   = {IDX_W{1'b0}};
    o_found = |i_vec;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      o_idx = i_vec[i] ? IDX_W'(i) : o_idx;
    end
  end

endmodule

// File: rtl/mb_cam_ctl.sv
// Miss-buffer controller driving the 16x40 CAM write, read and lookup ports.
// Optional index-match conflict reporting: define MB_CAM_CTL_IDX_MATCH_EN.
module mb_cam_ctl
  import mb_cam_ctl_pkg::*;
(
  input  logic               rclk,
  input  logic               rst_l,
  input  logic               req_vld,
  input  logic [PA_W-1:0]    req_pa,
  output logic               req_rdy,
  output logic               req_hit,
  output logic               req_alloc,
  output logic [IDX_W-1:0]   req_idx,
  output logic               req_idx_conflict,
  input  logic               fill_vld,
  input  logic [IDX_W-1:0]   fill_idx,
  output logic               fill_pa_vld,
  output logic [PA_W-1:0]    fill_pa,
  output logic               mb_full,
  output logic [CNT_W-1:0]   mb_cnt,
  output logic [ENTRIES-1:0] cam_adr_w,
  output logic [PA_W-1:0]    cam_din,
  output logic               cam_wen,
  output logic [ENTRIES-1:0] cam_adr_r,
  output logic               cam_ren,
  input  logic [PA_W-1:0]    cam_dout,
  output logic               cam_lookup_en,
  output logic [KEY_W-1:0]   cam_key,
  input  logic [ENTRIES-1:0] cam_match,
`ifdef MB_CAM_CTL_IDX_MATCH_EN
  input  logic [ENTRIES-1:0] cam_match_idx,
`endif
  input  logic               cam_dummy_unused_n
);

  mb_state_e           r_state;
  logic [ENTRIES-1:0]  r_vld;
  logic [CNT_W-1:0]    r_cnt;
  logic [PA_W-1:0]     r_pa;
  logic [IDX_W-1:0]    r_fill_idx;
  logic [IDX_W-1:0]    r_wr_idx;
  logic                r_req_hit;
  logic                r_req_alloc;
  logic [IDX_W-1:0]    r_req_idx;
  logic                r_fill_pa_vld;
  logic [PA_W-1:0]     r_fill_pa;
  logic [ENTRIES-1:0]  r_cam_adr_w;
  logic [PA_W-1:0]     r_cam_din;
  logic                r_cam_wen;
  logic [ENTRIES-1:0]  r_cam_adr_r;
  logic                r_cam_ren;
  logic                r_cam_lookup_en;
  logic [KEY_W-1:0]    r_cam_key;

  logic [ENTRIES-1:0]  w_qual_match;
  logic [IDX_W-1:0]    w_hit_idx;
  logic                w_hit;
  logic [IDX_W-1:0]    w_free_idx;
  logic                w_free_found;
  logic                w_req_acc;

  // Stale CAM contents of freed entries must never produce a hit
  assign w_qual_match = cam_match & r_vld;

  mb_pri_enc16 u_hit_enc (
    .i_vec   (w_qual_match),
    .o_idx   (w_hit_idx),
    .o_found (w_hit)
  );

  mb_pri_enc16 u_free_enc (
    .i_vec   (~r_vld),
    .o_idx   (w_free_idx),
    .o_found (w_free_found)
  );

  assign mb_full   = (r_cnt == CNT_W'(ENTRIES));
  assign req_rdy   = rst_l & (r_state == IDLE) & ~fill_vld & ~mb_full;
  assign w_req_acc = req_vld & req_rdy;

  // Transaction sequencer; every CAM strobe and result pulse is registered here
  always_ff @(posedge rclk or negedge rst_l) begin
    if (!rst_l) begin
      r_state         <= IDLE;
      r_vld           <= {ENTRIES{1'b0}};
      r_cnt           <= {CNT_W{1'b0}};
      r_pa            <= {PA_W{1'b0}};
      r_fill_idx      <= {IDX_W{1'b0}};
      r_wr_idx        <= {IDX_W{1'b0}};
      r_req_hit       <= 1'b0;
      r_req_alloc     <= 1'b0;
      r_req_idx       <= {IDX_W{1'b0}};
      r_fill_pa_vld   <= 1'b0;
      r_fill_pa       <= {PA_W{1'b0}};
      r_cam_adr_w     <= {ENTRIES{1'b0}};
      r_cam_din       <= {PA_W{1'b0}};
      r_cam_wen       <= 1'b0;
      r_cam_adr_r     <= {ENTRIES{1'b0}};
      r_cam_ren       <= 1'b0;
      r_cam_lookup_en <= 1'b0;
      r_cam_key       <= {KEY_W{1'b0}};
    end else begin
      r_req_hit       <= 1'b0;
      r_req_alloc     <= 1'b0;
      r_fill_pa_vld   <= 1'b0;
      r_cam_adr_w     <= {ENTRIES{1'b0}};
      r_cam_din       <= {PA_W{1'b0}};
      r_cam_wen       <= 1'b0;
      r_cam_adr_r     <= {ENTRIES{1'b0}};
      r_cam_ren       <= 1'b0;
      r_cam_lookup_en <= 1'b0;
      r_cam_key       <= {KEY_W{1'b0}};
      case (r_state)
        IDLE: begin
          if (fill_vld) begin
            if (r_vld[fill_idx]) begin
              r_fill_idx  <= fill_idx;
              r_cam_ren   <= 1'b1;
              r_cam_adr_r <= onehot16(fill_idx);
              r_state     <= RD;
            end
          end else if (w_req_acc) begin
            r_pa            <= req_pa;
            r_cam_lookup_en <= 1'b1;
            r_cam_key       <= req_pa[PA_W-1:KEY_LSB];
            r_state         <= LKP;
          end
        end
        LKP: r_state <= CMP;
        CMP: begin
          if (w_hit) begin
            r_req_hit <= 1'b1;
            r_req_idx <= w_hit_idx;
            r_state   <= IDLE;
          end else begin
            // req_rdy excludes a full buffer, so a free entry always exists here
            r_cam_wen   <= w_free_found;
            r_cam_adr_w <= onehot16(w_free_idx);
            r_cam_din   <= r_pa;
            r_wr_idx    <= w_free_idx;
            r_state     <= WR;
          end
        end
        WR: begin
          r_vld[r_wr_idx] <= 1'b1;
          r_cnt           <= r_cnt + 5'd1;
          r_req_alloc     <= 1'b1;
          r_req_idx       <= r_wr_idx;
          r_state         <= IDLE;
        end
        RD: r_state <= RDC;
        RDC: begin
          r_fill_pa         <= cam_dout;
          r_fill_pa_vld     <= 1'b1;
          r_vld[r_fill_idx] <= 1'b0;
          r_cnt             <= r_cnt - 5'd1;
          r_state           <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef MB_CAM_CTL_IDX_MATCH_EN
  logic r_conf_pend;
  logic r_conf;

  // Index conflict is captured on a miss and reported alongside the allocation
  always_ff @(posedge rclk or negedge rst_l) begin
    if (!rst_l) begin
      r_conf_pend <= 1'b0;
      r_conf      <= 1'b0;
    end else begin
      r_conf <= 1'b0;
      if ((r_state == CMP) && !w_hit) begin
        r_conf_pend <= |(cam_match_idx & r_vld);
      end
      if (r_state == WR) begin
        r_conf <= r_conf_pend;
      end
    end
  end

  assign req_idx_conflict = r_conf;
`else
  assign req_idx_conflict = 1'b0;
`endif

  assign req_hit       = r_req_hit;
  assign req_alloc     = r_req_alloc;
  assign req_idx       = r_req_idx;
  assign fill_pa_vld   = r_fill_pa_vld;
  assign fill_pa       = r_fill_pa;
  assign mb_cnt        = r_cnt;
  assign cam_adr_w     = r_cam_adr_w;
  assign cam_din       = r_cam_din;
  assign cam_wen       = r_cam_wen;
  assign cam_adr_r     = r_cam_adr_r;
  assign cam_ren       = r_cam_ren;
  assign cam_lookup_en = r_cam_lookup_en;
  assign cam_key       = r_cam_key;

  logic w_unused;
  assign w_unused = cam_dummy_unused_n;

endmodule

// File: tb/tb_mb_cam_ctl.sv
// Directed bench for mb_cam_ctl with a behavioural model of the CAM macro.
module tb_mb_cam_ctl;

  logic        rclk;
  logic        rst_l;
  logic        req_vld;
  logic [39:0] req_pa;
  logic        req_rdy;
  logic        req_hit;
  logic        req_alloc;
  logic [3:0]  req_idx;
  logic        req_idx_conflict;
  logic        fill_vld;
  logic [3:0]  fill_idx;
  logic        fill_pa_vld;
  logic [39:0] fill_pa;
  logic        mb_full;
  logic [4:0]  mb_cnt;
  logic [15:0] cam_adr_w;
  logic [39:0] cam_din;
  logic        cam_wen;
  logic [15:0] cam_adr_r;
  logic        cam_ren;
  logic [39:0] cam_dout;
  logic        cam_lookup_en;
  logic [31:0] cam_key;
  logic [15:0] cam_match;

  logic [39:0] mem    [16];
  logic [39:0] pa_tab [16];
  int          checks = 0;
  int          errors = 0;

`ifdef MB_CAM_CTL_IDX_MATCH_EN
  localparam logic CONF_EXP = 1'b1;
  logic [15:0] cam_match_idx;
`else
  localparam logic CONF_EXP = 1'b0;
`endif

  mb_cam_ctl dut (
    .rclk               (rclk),
    .rst_l              (rst_l),
    .req_vld            (req_vld),
    .req_pa             (req_pa),
    .req_rdy            (req_rdy),
    .req_hit            (req_hit),
    .req_alloc          (req_alloc),
    .req_idx            (req_idx),
    .req_idx_conflict   (req_idx_conflict),
    .fill_vld           (fill_vld),
    .fill_idx           (fill_idx),
    .fill_pa_vld        (fill_pa_vld),
    .fill_pa            (fill_pa),
    .mb_full            (mb_full),
    .mb_cnt             (mb_cnt),
    .cam_adr_w          (cam_adr_w),
    .cam_din            (cam_din),
    .cam_wen            (cam_wen),
    .cam_adr_r          (cam_adr_r),
    .cam_ren            (cam_ren),
    .cam_dout           (cam_dout),
    .cam_lookup_en      (cam_lookup_en),
    .cam_key            (cam_key),
    .cam_match          (cam_match),
`ifdef MB_CAM_CTL_IDX_MATCH_EN
    .cam_match_idx      (cam_match_idx),
`endif
    .cam_dummy_unused_n (1'b1)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  // CAM macro model: registered match, array write at the strobe edge, registered read
  always @(posedge rclk) begin
    if (cam_lookup_en) begin
      for (int i = 0; i < 16; i++) begin
        cam_match[i] <= (mem[i][39:8] == cam_key);
`ifdef MB_CAM_CTL_IDX_MATCH_EN
        cam_match_idx[i] <= (mem[i][38:8] == cam_key[30:0]);
`endif
      end
    end
    for (int i = 0; i < 16; i++) begin
      if (cam_wen && cam_adr_w[i]) mem[i] <= cam_din;
      if (cam_ren && cam_adr_r[i]) cam_dout <= mem[i];
    end
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge rclk);
    #1;
  endtask

  task automatic do_req(input logic [39:0] pa, input logic exp_hit, input logic [3:0] exp_idx,
                        input logic exp_conf, input string tag);
    int n;
    n       = 0;
    req_vld = 1'b1;
    req_pa  = pa;
    #1;
    while (!req_rdy && n < 50) begin
      step();
      n++;
    end
    check_val({tag, "_rdy"}, req_rdy, 1);
    step();
    req_vld = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      check_val({tag, "_lkp"}, cam_lookup_en, (k == 1));
      if (k == 1) check_val({tag, "_key"}, cam_key, pa[39:8]);
      check_val({tag, "_hit"}, req_hit, (exp_hit && k == 3));
      check_val({tag, "_alloc"}, req_alloc, (!exp_hit && k == 4));
      check_val({tag, "_wen"}, cam_wen, (!exp_hit && k == 3));
      if (!exp_hit && k == 3) begin
        check_val({tag, "_adrw"}, cam_adr_w, 16'h0001 << exp_idx);
        check_val({tag, "_din"}, cam_din, pa);
      end
      if ((exp_hit && k == 3) || (!exp_hit && k == 4)) begin
        check_val({tag, "_idx"}, req_idx, exp_idx);
        check_val({tag, "_conf"}, req_idx_conflict, (!exp_hit && exp_conf));
      end
      step();
    end
  endtask

  task automatic wait_fill(input logic [39:0] exp_pa, input string tag);
    int n;
    n = 0;
    while (!fill_pa_vld && n < 6) begin
      check_val({tag, "_nowen"}, cam_wen, 0);
      step();
      n++;
    end
    check_val({tag, "_pvld"}, fill_pa_vld, 1);
    check_val({tag, "_pa"}, fill_pa, exp_pa);
    step();
  endtask

  initial begin
    rst_l    = 1'b0;
    req_vld  = 1'b0;
    req_pa   = 40'h0;
    fill_vld = 1'b0;
    fill_idx = 4'd0;
    pa_tab[0] = 40'h12_3456_7800;
    for (int i = 1; i < 16; i++) pa_tab[i] = 40'h20_0000_0000 | (40'(i) << 12);
    repeat (3) @(posedge rclk);
    #1;
    check_val("rst_cnt", mb_cnt, 0);
    check_val("rst_full", mb_full, 0);
    check_val("rst_rdy", req_rdy, 0);
    check_val("rst_wen", cam_wen, 0);
    check_val("rst_lkp", cam_lookup_en, 0);
    check_val("rst_adrw", cam_adr_w, 0);
    check_val("rst_adrr", cam_adr_r, 0);
    rst_l = 1'b1;
    step();
    check_val("idle_rdy", req_rdy, 1);

    do_req(pa_tab[0], 1'b0, 4'd0, 1'b0, "alloc0");
    check_val("alloc0_cnt", mb_cnt, 1);
    do_req(pa_tab[0], 1'b1, 4'd0, 1'b0, "hit0");
    check_val("hit0_cnt", mb_cnt, 1);

    for (int i = 1; i < 16; i++) do_req(pa_tab[i], 1'b0, 4'(i), 1'b0, "fillup");
    check_val("full_cnt", mb_cnt, 16);
    check_val("full_flag", mb_full, 1);
    check_val("full_rdy", req_rdy, 0);

    req_vld = 1'b1;
    req_pa  = 40'h77_0000_0000;
    repeat (8) begin
      step();
      check_val("full_nolkp", cam_lookup_en, 0);
      check_val("full_norms", req_rdy, 0);
    end

    fill_vld = 1'b1;
    fill_idx = 4'd5;
    #1;
    check_val("prio_rdy", req_rdy, 0);
    step();
    fill_vld = 1'b0;
    req_vld  = 1'b0;
    check_val("prio_ren", cam_ren, 1);
    check_val("prio_adrr", cam_adr_r, 16'h0020);
    check_val("prio_nolkp", cam_lookup_en, 0);
    wait_fill(pa_tab[5], "fill5");
    check_val("fill5_cnt", mb_cnt, 15);
    check_val("fill5_full", mb_full, 0);

    fill_vld = 1'b1;
    fill_idx = 4'd5;
    step();
    fill_vld = 1'b0;
    repeat (4) begin
      check_val("inv_ren", cam_ren, 0);
      check_val("inv_pvld", fill_pa_vld, 0);
      step();
    end
    check_val("inv_cnt", mb_cnt, 15);
    do_req(pa_tab[5], 1'b0, 4'd5, 1'b0, "stale5");
    check_val("stale5_cnt", mb_cnt, 16);

    fill_vld = 1'b1;
    fill_idx = 4'd3;
    step();
    fill_vld = 1'b0;
    wait_fill(pa_tab[3], "fill3");
    req_vld = 1'b1;
    req_pa  = 40'h55_0000_0000;
    #1;
    check_val("mid_rdy", req_rdy, 1);
    step();
    req_vld = 1'b0;
    check_val("mid_lkp", cam_lookup_en, 1);
    step();
    #2;
    rst_l = 1'b0;
    #1;
    check_val("mid_cnt", mb_cnt, 0);
    check_val("mid_idx", req_idx, 0);
    check_val("mid_fpa", fill_pa, 0);
    check_val("mid_wen", cam_wen, 0);
    check_val("mid_adrw", cam_adr_w, 0);
    check_val("mid_din", cam_din, 0);
    check_val("mid_rdy0", req_rdy, 0);
    step();
    step();
    rst_l = 1'b1;
    repeat (3) begin
      check_val("post_hit", req_hit, 0);
      check_val("post_alloc", req_alloc, 0);
      step();
    end
    do_req(pa_tab[0], 1'b0, 4'd0, 1'b0, "post_rst");
    do_req(40'h92_3456_7800, 1'b0, 4'd1, CONF_EXP, "bit39");
    check_val("end_cnt", mb_cnt, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
